rr_decoder_arbiter: RTL and testbench

- Round-robin arbiter that shares one decoded resource among 4 requesters.
- Picks an owner, holds the grant until the owner releases it or a hold timeout expires, then rotates priority.
- Drives address0/address1/enable toward the 2-to-4 decoder path.
- Produces the one-hot grant by instantiating behavioralDecoder on the registered owner index.

---
 rtl/rr_decoder_arbiter_pkg.sv | 29 ++
 rtl/rr_decoder_arbiter_decoder.sv | 17 +
 rtl/rr_decoder_arbiter.sv | 96 +++++++++
 tb/tb_rr_decoder_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
// Holds the FSM encoding, the requester count and the rotating-priority pick helper.
package rr_decoder_arbiter_pkg;

    localparam int unsigned NUM_REQ          = 4;
    localparam int unsigned HOLD_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } state_t;

    // First requester at or after ptr (mod 4); returns ptr when nothing is requesting.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_decoder.sv
// Existing 2-to-4 behavioural decoder: one-hot output selected by {address1,address0}
// while enable is high, all zero otherwise.
module behavioralDecoder (
    input  logic       address0,
    input  logic       address1,
    input  logic       enable,
    output logic [3:0] decoded
);

    always_comb begin
        decoded = '0;
        if (enable) begin
            decoded[{address1, address0}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one decoded resource among 4 requesters, with a
// hold timeout and a one-cycle dead gap between successive owners.
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       address0,
    output logic       address1,
    output logic       enable,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);

    state_t             state, state_n;
    logic [1:0]         owner, owner_n;
    logic [1:0]         ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               timeout_n;
    logic               enable_q, enable_n;
    logic [1:0]         pick;

    assign pick = rr_pick(req, ptr);

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            BUSY: begin
                // Release outranks timeout so a simultaneous done never pulses timeout.
                if (done[owner] || !req[owner]) begin
                    state_n = GAP;
                    ptr_n   = owner + 2'd1;
                end else if (HOLD_MAX != 0 && cnt == CNT_LAST) begin
                    state_n   = GAP;
                    ptr_n     = owner + 2'd1;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (|req) begin
                    state_n = BUSY;
                    owner_n = pick;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
        enable_n = (state_n == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            cnt      <= '0;
            timeout  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            timeout  <= timeout_n;
            enable_q <= enable_n;
        end
    end

    assign address0    = owner[0];
    assign address1    = owner[1];
    assign enable      = enable_q;
    assign grant_valid = enable_q;

    behavioralDecoder u_decoder (
        .address0 (address0),
        .address1 (address1),
        .enable   (enable),
        .decoded  (grant)
    );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with HOLD_MAX=4; expected values are hand-computed.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_valid;
    logic       address0;
    logic       address1;
    logic       enable;
    logic       timeout;

    int tests    = 0;
    int failures = 0;

    rr_decoder_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .address0    (address0),
        .address1    (address1),
        .enable      (enable),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Grant plus the flags that must track it, and the timeout pulse.
    task automatic check_out(input string tag, input logic [3:0] exp_grant, input logic exp_timeout);
        check({tag, ".grant"}, grant, exp_grant);
        check({tag, ".grant_valid"}, {3'b000, grant_valid}, {3'b000, |exp_grant});
        check({tag, ".enable"}, {3'b000, enable}, {3'b000, |exp_grant});
        check({tag, ".timeout"}, {3'b000, timeout}, {3'b000, exp_timeout});
    endtask

    task automatic check_addr(input string tag, input logic [1:0] exp_addr);
        check({tag, ".addr"}, {2'b00, address1, address0}, {2'b00, exp_addr});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] g;
        reset_n = 1'b0;
        req     = '0;
        done    = '0;
        step();
        step();
        check_out("reset", 4'b0000, 1'b0);
        check_addr("reset", 2'b00);
        reset_n = 1'b1;
        step();
        check_out("idle", 4'b0000, 1'b0);

        // Single requester, release by done, gap, then idle
        req = 4'b0100;
        step();
        check_out("single_grant", 4'b0100, 1'b0);
        check_addr("single_grant", 2'b10);
        done = 4'b0100;
        step();
        check_out("single_gap", 4'b0000, 1'b0);
        done = '0;
        req  = '0;
        step();
        check_out("single_idle", 4'b0000, 1'b0);

        // All requesting, each owner releases after 2 grant cycles
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 4; k++) begin
            g = 4'b0001 << k;
            check_out("rot_first", g, 1'b0);
            step();
            check_out("rot_second", g, 1'b0);
            done = g;
            step();
            done = '0;
            check_out("rot_gap", 4'b0000, 1'b0);
            step();
        end
        check_out("rot_wrap", 4'b0001, 1'b0);
        req = '0;
        step();
        step();

        // Hold timeout: lone requester held for exactly HOLD_MAX cycles
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step();
            check_out("hold", 4'b0010, 1'b0);
        end
        step();
        check_out("revoke", 4'b0000, 1'b1);
        step();
        check_out("regrant", 4'b0010, 1'b0);
        check_addr("regrant", 2'b01);

        // done on the expiry cycle wins: release without timeout
        step();
        step();
        step();
        check_out("pre_expiry", 4'b0010, 1'b0);
        done = 4'b1110;
        step();
        check_out("done_beats_timeout", 4'b0000, 1'b0);
        done = 4'b1100;
        step();
        check_out("regrant2", 4'b0010, 1'b0);
        step();
        check_out("nonowner_done", 4'b0010, 1'b0);
        done = '0;

        // Reset in the middle of owner 3's grant
        req = 4'b1000;
        step();
        check_out("to_gap3", 4'b0000, 1'b0);
        step();
        check_out("owner3", 4'b1000, 1'b0);
        check_addr("owner3", 2'b11);
        reset_n = 1'b0;
        step();
        check_out("mid_reset", 4'b0000, 1'b0);
        check_addr("mid_reset", 2'b00);
        reset_n = 1'b1;
        req     = 4'b1001;
        step();
        check_out("post_reset", 4'b0001, 1'b0);

        // Owner drops req without done; pointer skips past it and wraps
        req = 4'b0100;
        step();
        check_out("drop0_gap", 4'b0000, 1'b0);
        step();
        check_out("owner2", 4'b0100, 1'b0);
        req = 4'b0011;
        step();
        check_out("drop2_gap", 4'b0000, 1'b0);
        req = 4'b0111;
        step();
        check_out("wrap_pick", 4'b0001, 1'b0);
        check_addr("wrap_pick", 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
